// File: rtl/pipe_pkg.sv
// Shared pipeline constants: memory opcodes, NOP encoding, opcode field
// position and the memory-stage state encoding.
package pipe_pkg;

  localparam logic [7:0]  OP_LOAD  = 8'h10;
  localparam logic [7:0]  OP_STORE = 8'h11;
  localparam logic [63:0] NOP_IR   = 64'h0;

  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 56;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_op_decoder.sv
// Classifies the incoming instruction as load/store and flags memory
// accesses whose effective address is not 64-bit aligned.
module mem_op_decoder
  import pipe_pkg::*;
(
  input  logic [7:0] opcode_i,
  input  logic [2:0] alu_lsb_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       misaligned_o
);

  assign is_load_o    = (opcode_i == OP_LOAD);
  assign is_store_o   = (opcode_i == OP_STORE);
  assign misaligned_o = (is_load_o | is_store_o) & (alu_lsb_i != 3'b000);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: 64-bit load/store over a req/ack port with
// timeout, registering IR/IR_old/mem_out/mem_in for write-back.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DMEM_AW = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        IR_in,
  input  logic [63:0]        alu_in,
  input  logic [63:0]        store_in,
  input  logic               valid_in,
  output logic               stall_out,
  output logic [63:0]        IR,
  output logic [63:0]        IR_old,
  output logic [63:0]        mem_out,
  output logic [63:0]        mem_in,
  output logic               valid_out,
  output logic               fault,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [63:0]        dmem_wdata,
  input  logic [63:0]        dmem_rdata,
  input  logic               dmem_ack
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   hold_ir_q;
  logic [63:0]   hold_alu_q;
  logic          hold_load_q;

  logic is_load_s;
  logic is_store_s;
  logic misaligned_s;

  mem_op_decoder u_dec (
    .opcode_i     (IR_in[OPC_MSB:OPC_LSB]),
    .alu_lsb_i    (alu_in[2:0]),
    .is_load_o    (is_load_s),
    .is_store_o   (is_store_s),
    .misaligned_o (misaligned_s)
  );

  assign stall_out = (state_q == ST_WAIT);

  // Stage FSM; mem_in/mem_out hold their last value on bubbles and faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_ir_q   <= 64'h0;
      hold_alu_q  <= 64'h0;
      hold_load_q <= 1'b0;
      IR          <= NOP_IR;
      IR_old      <= 64'h0;
      mem_out     <= 64'h0;
      mem_in      <= 64'h0;
      valid_out   <= 1'b0;
      fault       <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= 64'h0;
    end else begin
      IR_old <= IR;
      fault  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!valid_in) begin
            IR        <= NOP_IR;
            valid_out <= 1'b0;
          end else if (!(is_load_s || is_store_s)) begin
            IR        <= IR_in;
            mem_in    <= alu_in;
            mem_out   <= 64'h0;
            valid_out <= 1'b1;
          end else if (misaligned_s) begin
            IR        <= NOP_IR;
            valid_out <= 1'b0;
            fault     <= 1'b1;
          end else begin
            hold_ir_q   <= IR_in;
            hold_alu_q  <= alu_in;
            hold_load_q <= is_load_s;
            dmem_req    <= 1'b1;
            dmem_we     <= is_store_s;
            dmem_addr   <= alu_in[DMEM_AW-1:0];
            dmem_wdata  <= store_in;
            cnt_q       <= '0;
            IR          <= NOP_IR;
            valid_out   <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            IR        <= hold_ir_q;
            mem_in    <= hold_alu_q;
            mem_out   <= hold_load_q ? dmem_rdata : 64'h0;
            valid_out <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            dmem_req  <= 1'b0;
            fault     <= 1'b1;
            IR        <= NOP_IR;
            valid_out <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q     <= cnt_q + CW'(1);
            IR        <= NOP_IR;
            valid_out <= 1'b0;
          end
        end
        default: begin
          dmem_req  <= 1'b0;
          IR        <= NOP_IR;
          valid_out <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, hand-written
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_mem_access_stage;
  import pipe_pkg::*;

  localparam int AW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   IR_in = 64'h0, alu_in = 64'h0, store_in = 64'h0;
  logic          valid_in = 1'b0;
  logic          stall_out;
  logic [63:0]   IR, IR_old, mem_out, mem_in;
  logic          valid_out, fault, dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [63:0]   dmem_wdata;
  logic [63:0]   dmem_rdata = 64'h0;
  logic          dmem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.DMEM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .alu_in(alu_in), .store_in(store_in),
    .valid_in(valid_in), .stall_out(stall_out), .IR(IR), .IR_old(IR_old),
    .mem_out(mem_out), .mem_in(mem_in), .valid_out(valid_out), .fault(fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_fn(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  typedef struct {
    logic [63:0] ir;
    logic [63:0] alu;
    logic        valid;
    logic [63:0] exp_ir;
    logic [63:0] exp_mem_in;
    logic        exp_vo;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[6];

  // Reference model state (transaction level)
  bit          m_busy = 1'b0;
  int          m_waited = 0;
  int          lat = 1;
  logic [63:0] m_hir = 64'h0, m_halu = 64'h0;
  bit          m_hload = 1'b0;
  logic [63:0] e_ir = 64'h0, e_ir_old = 64'h0, e_mem_out = 64'h0, e_mem_in = 64'h0;
  logic [63:0] e_addr = 64'h0, e_wdata = 64'h0;
  logic        e_vo = 1'b0, e_fault = 1'b0, e_req = 1'b0, e_we = 1'b0;

  initial begin
    logic [63:0] prev_ir;
    logic [63:0] ir_l, ir_s;
    logic [7:0]  op;

    tbl[0] = '{64'h2000_0000_0000_0001, 64'h5, 1'b1, 64'h2000_0000_0000_0001, 64'h5, 1'b1, 1'b0};
    tbl[1] = '{64'h3300_0000_0000_00FF, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0};
    tbl[2] = '{{OP_LOAD, 56'h0}, 64'h43, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1};
    tbl[3] = '{64'h1200_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1,
               64'h1200_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0};
    tbl[4] = '{{OP_STORE, 56'h1}, 64'h4, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1};
    tbl[5] = '{64'h0F00_0000_0000_0009, 64'h123, 1'b1, 64'h0F00_0000_0000_0009, 64'h123, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_IR", IR, 64'h0);
    chk("rst_IR_old", IR_old, 64'h0);
    chk("rst_valid", {63'h0, valid_out}, 64'h0);
    chk("rst_req", {63'h0, dmem_req}, 64'h0);
    chk("rst_stall", {63'h0, stall_out}, 64'h0);
    cyc();
    rst_n = 1'b1;

    // Single-cycle IDLE vectors
    prev_ir = 64'h0;
    for (int i = 0; i < 6; i++) begin
      IR_in = tbl[i].ir; alu_in = tbl[i].alu; valid_in = tbl[i].valid; store_in = 64'hABCD;
      cyc();
      chk($sformatf("tbl%0d_IR", i), IR, tbl[i].exp_ir);
      chk($sformatf("tbl%0d_IR_old", i), IR_old, prev_ir);
      chk($sformatf("tbl%0d_valid", i), {63'h0, valid_out}, {63'h0, tbl[i].exp_vo});
      chk($sformatf("tbl%0d_fault", i), {63'h0, fault}, {63'h0, tbl[i].exp_fault});
      chk($sformatf("tbl%0d_req", i), {63'h0, dmem_req}, 64'h0);
      chk($sformatf("tbl%0d_stall", i), {63'h0, stall_out}, 64'h0);
      if (tbl[i].exp_vo) begin
        chk($sformatf("tbl%0d_mem_in", i), mem_in, tbl[i].exp_mem_in);
        chk($sformatf("tbl%0d_mem_out", i), mem_out, 64'h0);
      end
      prev_ir = tbl[i].exp_ir;
    end
    valid_in = 1'b0;
    cyc();
    chk("post_tbl_fault", {63'h0, fault}, 64'h0);

    // Load with ack one cycle after request
    ir_l = {OP_LOAD, 56'h00_0000_0000_0A01};
    IR_in = ir_l; alu_in = 64'h40; store_in = 64'h0; valid_in = 1'b1;
    cyc();
    chk("ld_req", {63'h0, dmem_req}, 64'h1);
    chk("ld_addr", {48'h0, dmem_addr}, 64'h40);
    chk("ld_we", {63'h0, dmem_we}, 64'h0);
    chk("ld_stall", {63'h0, stall_out}, 64'h1);
    chk("ld_bubble", {63'h0, valid_out}, 64'h0);
    dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
    cyc();
    valid_in = 1'b0; dmem_ack = 1'b0;
    chk("ld_stall_end", {63'h0, stall_out}, 64'h0);
    chk("ld_req_end", {63'h0, dmem_req}, 64'h0);
    chk("ld_IR", IR, ir_l);
    chk("ld_mem_out", mem_out, 64'hDEAD_BEEF);
    chk("ld_mem_in", mem_in, 64'h40);
    chk("ld_valid", {63'h0, valid_out}, 64'h1);

    // Store with ack after three cycles
    ir_s = {OP_STORE, 56'h00_0000_0000_0B02};
    IR_in = ir_s; alu_in = 64'h88; store_in = 64'h1234; valid_in = 1'b1;
    cyc();
    chk("st_we", {63'h0, dmem_we}, 64'h1);
    chk("st_wdata", dmem_wdata, 64'h1234);
    chk("st_addr", {48'h0, dmem_addr}, 64'h88);
    chk("st_stall0", {63'h0, stall_out}, 64'h1);
    for (int i = 1; i < 3; i++) begin
      cyc();
      chk($sformatf("st_stall%0d", i), {63'h0, stall_out}, 64'h1);
      chk($sformatf("st_req%0d", i), {63'h0, dmem_req}, 64'h1);
    end
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    valid_in = 1'b0; dmem_ack = 1'b0;
    chk("st_stall_end", {63'h0, stall_out}, 64'h0);
    chk("st_mem_out", mem_out, 64'h0);
    chk("st_IR", IR, ir_s);
    chk("st_valid", {63'h0, valid_out}, 64'h1);

    // Timeout: no ack at all
    IR_in = ir_l; alu_in = 64'h100; valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    for (int i = 1; i < TO; i++) begin
      cyc();
      chk($sformatf("to_stall%0d", i), {63'h0, stall_out}, 64'h1);
      chk($sformatf("to_fault%0d", i), {63'h0, fault}, 64'h0);
    end
    cyc();
    chk("to_req", {63'h0, dmem_req}, 64'h0);
    chk("to_fault", {63'h0, fault}, 64'h1);
    chk("to_stall", {63'h0, stall_out}, 64'h0);
    chk("to_valid", {63'h0, valid_out}, 64'h0);
    cyc();
    chk("to_fault_pulse", {63'h0, fault}, 64'h0);

    // Reset two cycles into WAIT, then a late ack
    IR_in = ir_l; alu_in = 64'h200; valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {63'h0, dmem_req}, 64'h0);
    chk("arst_stall", {63'h0, stall_out}, 64'h0);
    chk("arst_IR", IR, 64'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'h1111;
    cyc();
    dmem_ack = 1'b0;
    chk("late_ack_valid", {63'h0, valid_out}, 64'h0);
    chk("late_ack_IR", IR, 64'h0);
    chk("late_ack_stall", {63'h0, stall_out}, 64'h0);
    chk("late_ack_mem_out", mem_out, 64'h0);

    // Random traffic against the model (DUT is idle, all outputs zero)
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_IR", IR, e_ir);
      chk("rnd_IR_old", IR_old, e_ir_old);
      chk("rnd_valid", {63'h0, valid_out}, {63'h0, e_vo});
      chk("rnd_fault", {63'h0, fault}, {63'h0, e_fault});
      chk("rnd_stall", {63'h0, stall_out}, {63'h0, m_busy});
      chk("rnd_req", {63'h0, dmem_req}, {63'h0, e_req});
      if (e_vo) begin
        chk("rnd_mem_in", mem_in, e_mem_in);
        chk("rnd_mem_out", mem_out, e_mem_out);
      end
      if (e_req) begin
        chk("rnd_addr", {48'h0, dmem_addr}, e_addr);
        chk("rnd_we", {63'h0, dmem_we}, {63'h0, e_we});
        chk("rnd_wdata", dmem_wdata, e_wdata);
      end

      case ($urandom_range(0, 3))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        default: op = 8'($urandom);
      endcase
      IR_in = {op, 24'($urandom), 32'($urandom)};
      alu_in = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) alu_in[2:0] = 3'b000;
      store_in = {32'($urandom), 32'($urandom)};
      valid_in = ($urandom_range(0, 4) != 0);
      if (m_busy) dmem_ack = (m_waited + 1 == lat);
      else        dmem_ack = ($urandom_range(0, 4) == 0);
      dmem_rdata = (m_busy && dmem_ack) ? mem_fn(dmem_addr) : {32'($urandom), 32'($urandom)};

      e_ir_old = e_ir;
      e_fault = 1'b0;
      if (!m_busy) begin
        if (!valid_in) begin
          e_ir = 64'h0; e_vo = 1'b0;
        end else if (IR_in[63:56] != OP_LOAD && IR_in[63:56] != OP_STORE) begin
          e_ir = IR_in; e_mem_in = alu_in; e_mem_out = 64'h0; e_vo = 1'b1;
        end else if (alu_in % 8 != 0) begin
          e_ir = 64'h0; e_vo = 1'b0; e_fault = 1'b1;
        end else begin
          m_busy = 1'b1; m_waited = 0;
          m_hir = IR_in; m_halu = alu_in; m_hload = (IR_in[63:56] == OP_LOAD);
          e_req = 1'b1; e_we = !m_hload; e_addr = alu_in % 65536; e_wdata = store_in;
          e_ir = 64'h0; e_vo = 1'b0;
          lat = ($urandom_range(0, 5) == 0) ? TO + 1 : int'($urandom_range(1, TO));
        end
      end else begin
        m_waited++;
        if (dmem_ack) begin
          e_req = 1'b0; m_busy = 1'b0;
          e_ir = m_hir; e_mem_in = m_halu; e_vo = 1'b1;
          e_mem_out = m_hload ? mem_fn(m_halu[15:0]) : 64'h0;
        end else if (m_waited == TO) begin
          e_req = 1'b0; m_busy = 1'b0; e_fault = 1'b1;
          e_ir = 64'h0; e_vo = 1'b0;
        end else begin
          e_ir = 64'h0; e_vo = 1'b0;
        end
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
